signed_accumulator: RTL and testbench
=====================================

Name: signed_accumulator

Overview:
- Sequential consumer of the 4-bit two's-complement values produced by the combinational two_s_complement stage.
- Accepts a frame of COUNT signed samples over a valid/ready handshake and sign-extends each to ACC_W bits.
- Adds the samples, then presents the frame sum with a sticky signed-overflow flag until downstream acknowledges.
- Used by lab datapaths that need running signed sums, e.g. A - B computed as A + (-B).

Parameters:
- IN_W, 4, input sample width, two's complement
- ACC_W, 8, accumulator/sum width, two's complement; must be >= IN_W
- COUNT, 4, samples per frame; must be >= 1

Ports:
- clk  input  1  rising-edge clock, the block's only clock
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous frame abort
- in_valid  input  1  in_data holds a sample
- in_data  input  IN_W  signed sample
- in_ready  output  1  block can accept a sample this cycle
- out_ready  input  1  downstream accepts the result
- sum_valid  output  1  sum/overflow hold a completed frame
- sum  output  ACC_W  signed frame sum
- overflow  output  1  sticky: signed overflow occurred in this frame
- sample_cnt  output  $clog2(COUNT+1)  samples accepted in the current frame

Behaviour:
- Reset (rst=1, asynchronous, any state):
  - state=IDLE, sum=0, overflow=0, sample_cnt=0, sum_valid=0.
  - in_ready=1 while in IDLE or ACCUM, so it reads 1 during reset.
- Priority: rst > clear > handshakes.
- clear=1 at a clock edge: same result as reset on that edge, synchronously; any sample offered that cycle is dropped.
- Accept: a sample is taken on a rising edge when in_valid && in_ready. in_data is ignored otherwise.
- Sign extension: ext = {(ACC_W-IN_W){in_data[IN_W-1]}, in_data}.
- FSM states: IDLE, ACCUM, DONE.
  - in_ready = (state != DONE), decoded directly from state.
  - sum_valid = (state == DONE), decoded directly from state.
- IDLE, on accept:
  - sum <= ext, overflow <= 0, sample_cnt <= 1.
  - Next state is DONE if COUNT==1, else ACCUM.
- ACCUM, on accept:
  - sum <= sum + ext, wrapping modulo 2^ACC_W; sample_cnt <= sample_cnt+1.
  - overflow <= overflow | ((sum[MSB]==ext[MSB]) && (result[MSB]!=sum[MSB])).
  - Moves to DONE on the edge that accepts sample COUNT.
- DONE:
  - sum, overflow and sample_cnt (=COUNT) are held stable; in_valid is ignored.
  - On out_ready=1 at an edge: go to IDLE, sample_cnt <= 0, sum_valid drops the next cycle.
  - sum and overflow keep their last value in IDLE until the next frame's first accept.
- Latency: sum_valid rises on the same edge that accepts the COUNTth sample. Minimum frame time is COUNT cycles plus 1 handshake cycle.
- Back-to-back frames: the first sample of the next frame can be accepted on the cycle after the DONE→IDLE edge.
- No input samples are ever lost or double-counted. A stalled in_valid does not advance sample_cnt.

Test Plan:
- Basic frame: after reset, send 4'b0011, 4'b1111, 4'b1000, 4'b0111 on consecutive cycles, out_ready=1 → sum=8'h01 (3-1-8+7), overflow=0, sum_valid high exactly 1 cycle after the 4th accept.
- Most negative frame: four samples of 4'b1000 → sum=8'hE0 (-32), overflow=0. Then four of 4'b0111 → sum=8'h1C (28).
- Backpressure: complete a frame with out_ready=0 for 3 cycles while in_valid=1 and in_data toggles → in_ready=0, sum/sum_valid stable; out_ready=1 → IDLE next cycle, and those toggled samples are not counted.
- Input gaps: same frame as the basic case with in_valid=0 for 2 cycles between each sample → identical sum=8'h01, and sample_cnt steps 1,2,3,4 only on accepts.
- Overflow (ACC_W=5): four samples of 4'b0111 → sum=5'b11100 (wrapped 28), overflow=1. The next frame of four 4'b0001 → overflow=0, sum=5'd4.
- Reset/clear mid-frame: after 2 accepts assert rst asynchronously between edges → outputs zero immediately. Repeat with clear → zeroed at the next edge. A fresh 4-sample frame then yields the correct sum.

Source files
------------

// File: rtl/signed_accumulator.sv
// Frame accumulator: sums COUNT sign-extended samples over a valid/ready
// handshake and holds the sum with a sticky signed-overflow flag until acknowledged.
module signed_accumulator #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [IN_W-1:0]              in_data,
    output logic                         in_ready,
    input  logic                         out_ready,
    output logic                         sum_valid,
    output logic [ACC_W-1:0]             sum,
    output logic                         overflow,
    output logic [$clog2(COUNT+1)-1:0]   sample_cnt
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ACC_W-1:0]   ext;
    logic [ACC_W-1:0]   acc_result;
    logic               ovf_step;
    logic               accept;

    assign ext        = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign acc_result = sum_q + ext;
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf_step   = (sum_q[ACC_W-1] == ext[ACC_W-1]) &&
                        (acc_result[ACC_W-1] != sum_q[ACC_W-1]);

    assign in_ready   = (state_q != DONE);
    assign sum_valid  = (state_q == DONE);
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            sum_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sum_d   = ext;
                        ovf_d   = 1'b0;
                        cnt_d   = CNT_W'(1);
                        state_d = (COUNT == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sum_d = acc_result;
                        ovf_d = ovf_q | ovf_step;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum        = sum_q;
    assign overflow   = ovf_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Directed bench: an 8-bit and a 5-bit accumulator share one input stream,
// each checked against hand-computed frame sums and overflow flags.
module tb_signed_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready8, sum_valid8, overflow8;
    logic [7:0] sum8;
    logic [2:0] cnt8;
    logic       in_ready5, sum_valid5, overflow5;
    logic [4:0] sum5;
    logic [2:0] cnt5;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    signed_accumulator #(.IN_W(4), .ACC_W(8), .COUNT(4)) u_acc8 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
        .out_ready(out_ready), .sum_valid(sum_valid8), .sum(sum8),
        .overflow(overflow8), .sample_cnt(cnt8)
    );

    signed_accumulator #(.IN_W(4), .ACC_W(5), .COUNT(4)) u_acc5 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready5),
        .out_ready(out_ready), .sum_valid(sum_valid5), .sum(sum5),
        .overflow(overflow5), .sample_cnt(cnt5)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s obs=0x%0h", tag, obs);
        end else begin
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for one edge, then withdraw it.
    task automatic send(input logic [3:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero8(input string tag);
        check_eq({tag, "_sum"}, 32'(sum8), 32'h00);
        check_eq({tag, "_cnt"}, 32'(cnt8), 32'd0);
        check_eq({tag, "_vld_rdy_ovf"}, {29'd0, sum_valid8, in_ready8, overflow8}, 32'b010);
    endtask

    logic [3:0] basic [4];

    initial begin
        basic[0] = 4'b0011; basic[1] = 4'b1111; basic[2] = 4'b1000; basic[3] = 4'b0111;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        #2;
        check_zero8("reset");
        idle_cycles(2);
        rst = 1'b0;
        tick();

        // Basic frame: 3 - 1 - 8 + 7 = 1
        for (int i = 0; i < 4; i++) begin
            send(basic[i]);
            check_eq($sformatf("basic_cnt%0d", i + 1), 32'(cnt8), 32'(i + 1));
            if (i < 3) check_eq($sformatf("basic_vld%0d", i + 1), 32'(sum_valid8), 32'd0);
        end
        check_eq("basic_sum", 32'(sum8), 32'h01);
        check_eq("basic_ovf", 32'(overflow8), 32'd0);
        check_eq("basic_vld", 32'(sum_valid8), 32'd1);
        check_eq("basic_rdy", 32'(in_ready8), 32'd0);
        tick();
        check_eq("basic_vld_drop", 32'(sum_valid8), 32'd0);
        check_eq("basic_cnt_clr", 32'(cnt8), 32'd0);
        check_eq("basic_sum_hold", 32'(sum8), 32'h01);

        // Most negative: 4 x -8; 5-bit copy wraps at -24 and flags overflow
        for (int i = 0; i < 4; i++) send(4'b1000);
        check_eq("neg_sum8", 32'(sum8), 32'hE0);
        check_eq("neg_ovf8", 32'(overflow8), 32'd0);
        check_eq("neg_sum5", 32'(sum5), 32'h00);
        check_eq("neg_ovf5", 32'(overflow5), 32'd1);
        tick();
        // Most positive: 4 x 7 = 28; 5-bit copy wraps to 11100
        for (int i = 0; i < 4; i++) send(4'b0111);
        check_eq("pos_sum8", 32'(sum8), 32'h1C);
        check_eq("pos_ovf8", 32'(overflow8), 32'd0);
        check_eq("pos_sum5", 32'(sum5), 32'b11100);
        check_eq("pos_ovf5", 32'(overflow5), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) send(4'b0001);
        check_eq("ones_sum5", 32'(sum5), 32'd4);
        check_eq("ones_ovf5", 32'(overflow5), 32'd0);
        check_eq("ones_sum8", 32'(sum8), 32'h04);
        tick();

        // Backpressure: 1+2+3+4 = 10, then toggling samples must be ignored
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'(i + 1));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = (i % 2 == 0) ? 4'b0111 : 4'b1000;
            tick();
            check_eq($sformatf("bp_rdy%0d", i), 32'(in_ready8), 32'd0);
            check_eq($sformatf("bp_vld%0d", i), 32'(sum_valid8), 32'd1);
            check_eq($sformatf("bp_sum%0d", i), 32'(sum8), 32'h0A);
            check_eq($sformatf("bp_cnt%0d", i), 32'(cnt8), 32'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_vld", 32'(sum_valid8), 32'd0);
        check_eq("bp_release_rdy", 32'(in_ready8), 32'd1);
        check_eq("bp_release_sum", 32'(sum8), 32'h0A);

        // Input gaps: count advances only on accepts
        for (int i = 0; i < 4; i++) begin
            send(basic[i]);
            check_eq($sformatf("gap_cnt%0d", i + 1), 32'(cnt8), 32'(i + 1));
            if (i < 3) begin
                idle_cycles(2);
                check_eq($sformatf("gap_hold%0d", i + 1), 32'(cnt8), 32'(i + 1));
            end
        end
        check_eq("gap_sum", 32'(sum8), 32'h01);
        check_eq("gap_ovf", 32'(overflow8), 32'd0);
        tick();

        // Asynchronous reset between edges mid-frame
        send(4'b0101);
        send(4'b0110);
        check_eq("pre_rst_cnt", 32'(cnt8), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_zero8("async_rst");
        #1 rst = 1'b0;
        tick();

        // Synchronous clear drops the sample offered on the same edge
        send(4'b0101);
        send(4'b0110);
        check_eq("pre_clr_sum", 32'(sum8), 32'h0B);
        clear = 1'b1;
        send(4'b0011);
        clear = 1'b0;
        check_zero8("clear");

        // Fresh frame after abort
        for (int i = 0; i < 4; i++) send(basic[i]);
        check_eq("fresh_sum", 32'(sum8), 32'h01);
        check_eq("fresh_vld", 32'(sum_valid8), 32'd1);
        check_eq("fresh_ovf", 32'(overflow8), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
